uart_tx_arbiter: RTL and testbench

//  Shares one UART byte transmitter between N_REQ requesters.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake and transmitter start/busy/done signals shared by the arbiter.
// The arbiter connects through the slave modport; the clients and the transmitter drive the master side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    tx_done;

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ requesters,
// with packet locking on req_last and a hold timeout that frees a stalled packet owner.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.slave         bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     locked,
  output logic                     hold_err
);
  localparam int              ID_W     = $clog2(N_REQ);
  localparam int              HC_W     = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [ID_W:0]   N_L      = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [HC_W-1:0] HC_LIMIT = HC_W'(HOLD_TIMEOUT - 1);
  localparam logic [HC_W-1:0] HC_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    HOLD,
    RELEASE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic              last_q;
  logic              resume;
  logic              timeout;
  logic [HC_W-1:0]   hold_cnt;
  logic [DATA_W-1:0] grant_data;

  // Search rr_ptr, rr_ptr+1, ... mod N_REQ; iterating downwards lets the nearest hit win.
  always_comb begin
    logic [ID_W:0] pos;
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    pos       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (pos >= N_L) pos = pos - N_L;
      if (bus.req_valid[pos[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = pos[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) grant_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign resume  = bus.req_valid[grant_id] & ~bus.tx_busy;
  assign timeout = (hold_cnt == HC_LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!bus.tx_busy && win_found) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done) state_nxt = last_q ? RELEASE : HOLD;
      HOLD: begin
        if (resume)       state_nxt = ISSUE;
        else if (timeout) state_nxt = RELEASE;
      end
      RELEASE:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Grant, lock, pointer and hold counter; a reset mid-frame simply drops the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id <= '0;
      locked   <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (state_nxt == ISSUE) begin
            grant_id <= win_id;
            locked   <= 1'b1;
          end
        end
        ISSUE: begin
          hold_cnt <= '0;
          last_q   <= bus.req_last[grant_id];
        end
        WAIT_DONE: if (bus.tx_done) hold_cnt <= '0;
        HOLD:      if (!resume && hold_cnt != HC_MAX) hold_cnt <= hold_cnt + 1'b1;
        RELEASE: begin
          locked <= 1'b0;
          rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: start/ready are pure decodes of ISSUE, which never lasts two cycles.
  always_comb begin
    bus.req_ready = '0;
    bus.tx_start  = 1'b0;
    bus.tx_data   = '0;
    hold_err      = 1'b0;
    unique case (state)
      ISSUE: begin
        bus.req_ready[grant_id] = 1'b1;
        bus.tx_start            = 1'b1;
        bus.tx_data             = grant_data;
      end
      HOLD:    hold_err = !resume && timeout;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester traffic, a transmitter model,
// and a monitor that checks every tx_start against hand-computed expected grants.
module tb_uart_tx_arbiter;
  localparam int N_REQ        = 4;
  localparam int DATA_W       = 8;
  localparam int HOLD_TIMEOUT = 16;
  localparam int TX_DLY       = 10;
  localparam int SRC_DEPTH    = 8;

  typedef struct {
    int          id;
    logic [7:0]  data;
    bit          gap2;
    int          at_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_id;
  logic       locked;
  logic       hold_err;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .DATA_W      (DATA_W),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .grant_id(grant_id),
    .locked  (locked),
    .hold_err(hold_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       sb[$];
  exp_t       e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_cyc = -100;
  bit         prev_start = 1'b0;
  logic [8:0] src_mem [N_REQ][SRC_DEPTH];
  int         src_head [N_REQ];
  int         src_tail [N_REQ];
  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;
  int         tx_cnt = 0;
  logic       start_seen;
  logic [N_REQ-1:0] ready_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_src(input int id, input logic [7:0] d, input bit last);
    src_mem[id][src_tail[id] % SRC_DEPTH] = {last, d};
    src_tail[id]++;
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d, input bit gap2, input int at_cyc);
    exp_t x;
    x.id = id; x.data = d; x.gap2 = gap2; x.at_cyc = at_cyc;
    sb.push_back(x);
  endtask

  function automatic bit src_empty();
    bit r = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (src_head[i] != src_tail[i]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !locked && !model_busy && src_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Requester queues and transmitter model: react to the handshake seen in the previous cycle.
  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      start_seen = bus.tx_start;
      ready_seen = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++)
        if (ready_seen[i] && src_head[i] != src_tail[i]) src_head[i]++;
      if (start_seen) begin
        model_busy  = 1'b1;
        bus.tx_done = 1'b0;
        tx_cnt      = TX_DLY - 1;
      end else if (bus.tx_done) begin
        bus.tx_done = 1'b0;
        model_busy  = 1'b0;
      end else if (model_busy) begin
        tx_cnt--;
        if (tx_cnt == 0) bus.tx_done = 1'b1;
      end
      bus.tx_busy = model_busy | force_busy;
      for (int i = 0; i < N_REQ; i++) begin
        bus.req_valid[i] = (src_head[i] != src_tail[i]);
        if (bus.req_valid[i]) begin
          bus.req_last[i]                      = src_mem[i][src_head[i] % SRC_DEPTH][8];
          bus.req_data[i*DATA_W +: DATA_W]     = src_mem[i][src_head[i] % SRC_DEPTH][7:0];
        end else begin
          bus.req_last[i]                      = 1'b0;
          bus.req_data[i*DATA_W +: DATA_W]     = '0;
        end
      end
    end
  end

  // Monitor: per-cycle handshake invariants, and scoreboard compare on every tx_start.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_done) done_cyc = cyc;
      check("ready_decode", 32'(bus.req_ready), bus.tx_start ? (32'd1 << grant_id) : 32'd0);
      check("ready_without_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
      if (bus.tx_start) begin
        check("start_back_to_back", 32'(prev_start), 32'd0);
        check("locked_at_start", 32'(locked), 32'd1);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start: got grant %0d data %0h, expected no transfer (cycle %0d)",
                   grant_id, bus.tx_data, cyc);
        end else begin
          e = sb.pop_front();
          check("grant_id", 32'(grant_id), 32'(e.id));
          check("tx_data", 32'(bus.tx_data), 32'(e.data));
          if (e.gap2)        check("done_to_start_gap", 32'(cyc - done_cyc), 32'd2);
          if (e.at_cyc >= 0) check("start_cycle", 32'(cyc), 32'(e.at_cyc));
        end
      end
      prev_start = bus.tx_start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;

    // T1/T2: all requesters valid through reset, then round-robin 0,1,2,3,0.
    push_src(0, 8'h10, 1'b1);
    push_src(1, 8'h21, 1'b1);
    push_src(2, 8'h32, 1'b1);
    push_src(3, 8'h43, 1'b1);
    push_src(0, 8'h14, 1'b1);
    expect_tx(0, 8'h10, 1'b0, -1);
    expect_tx(1, 8'h21, 1'b0, -1);
    expect_tx(2, 8'h32, 1'b0, -1);
    expect_tx(3, 8'h43, 1'b0, -1);
    expect_tx(0, 8'h14, 1'b0, -1);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_tx_start", 32'(bus.tx_start), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_hold_err", 32'(hold_err), 32'd0);
    end
    rst = 1'b0;
    wait_drain("drain_round_robin", 400);

    // T3: requester 1 owns the link for a 3-byte packet while requester 2 waits.
    push_src(1, 8'hB1, 1'b0);
    push_src(1, 8'hB2, 1'b0);
    push_src(1, 8'hB3, 1'b1);
    push_src(2, 8'hC1, 1'b1);
    expect_tx(1, 8'hB1, 1'b0, -1);
    expect_tx(1, 8'hB2, 1'b1, -1);
    expect_tx(1, 8'hB3, 1'b1, -1);
    expect_tx(2, 8'hC1, 1'b0, -1);
    wait_drain("drain_packet_lock", 400);

    // T4: requester 3 stalls mid-packet; timeout releases and pointer moves to 0.
    push_src(3, 8'hD1, 1'b0);
    expect_tx(3, 8'hD1, 1'b0, -1);
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (hold_err) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_err_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("hold_err_delay", 32'(cyc - done_cyc), 32'd16);
      @(negedge clk);
      check("hold_err_one_cycle", 32'(hold_err), 32'd0);
      @(negedge clk);
      check("locked_after_timeout", 32'(locked), 32'd0);
    end
    push_src(0, 8'hE0, 1'b1);
    push_src(1, 8'hE1, 1'b1);
    push_src(2, 8'hE2, 1'b1);
    push_src(3, 8'hE3, 1'b1);
    expect_tx(0, 8'hE0, 1'b0, -1);
    expect_tx(1, 8'hE1, 1'b0, -1);
    expect_tx(2, 8'hE2, 1'b0, -1);
    expect_tx(3, 8'hE3, 1'b0, -1);
    wait_drain("drain_after_timeout", 400);

    // T5: transmitter busy for 20 cycles blocks arbitration.
    @(negedge clk);
    force_busy = 1'b1;
    push_src(0, 8'hF0, 1'b1);
    repeat (20) @(negedge clk);
    force_busy = 1'b0;
    expect_tx(0, 8'hF0, 1'b0, cyc + 2);
    wait_drain("drain_busy_block", 200);

    // T6: reset while requester 2 is in HOLD; pointer returns to 0.
    push_src(2, 8'hC6, 1'b0);
    expect_tx(2, 8'hC6, 1'b0, -1);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_locked", 32'(locked), 32'd0);
    check("rst_mid_grant_id", 32'(grant_id), 32'd0);
    check("rst_mid_tx_start", 32'(bus.tx_start), 32'd0);
    rst = 1'b0;
    push_src(0, 8'h06, 1'b1);
    push_src(1, 8'h17, 1'b1);
    push_src(2, 8'hC7, 1'b1);
    expect_tx(0, 8'h06, 1'b0, -1);
    expect_tx(1, 8'h17, 1'b0, -1);
    expect_tx(2, 8'hC7, 1'b0, -1);
    wait_drain("drain_after_reset", 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
